// File: rtl/aggregator_fetch_scheduler_if.sv
// rtl/aggregator_fetch_scheduler_if.sv - requester and aggregator signals of the fetch scheduler
interface aggregator_fetch_scheduler_if #(
    parameter int NUM_REQ   = 3,
    parameter int FW_BITS   = 3,
    parameter int NVEC_BITS = 16
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*FW_BITS-1:0]   req_fetch_width;
    logic [NUM_REQ*NVEC_BITS-1:0] req_num_vectors;
    logic [NUM_REQ-1:0]           grant;
    logic [IDX_W-1:0]             grant_idx;
    logic [NUM_REQ-1:0]           done;
    logic                         busy;
    logic                         agg_change_fetch_width;
    logic [FW_BITS-1:0]           agg_fetch_width;
    logic                         agg_stream_en;
    logic                         agg_sender_deq;
    logic                         agg_receiver_enq;

    modport slave (
        input  req, req_fetch_width, req_num_vectors, agg_sender_deq, agg_receiver_enq,
        output grant, grant_idx, done, busy, agg_change_fetch_width, agg_fetch_width, agg_stream_en
    );

    modport master (
        output req, req_fetch_width, req_num_vectors, agg_sender_deq, agg_receiver_enq,
        input  grant, grant_idx, done, busy, agg_change_fetch_width, agg_fetch_width, agg_stream_en
    );
endinterface

// File: rtl/aggregator_fetch_scheduler.sv
// rtl/aggregator_fetch_scheduler.sv - round-robin sharing of one aggregator among fetch requesters
module aggregator_fetch_scheduler #(
    parameter int NUM_REQ   = 3,
    parameter int FW_BITS   = 3,
    parameter int NVEC_BITS = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    aggregator_fetch_scheduler_if.slave  bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WL_W  = NVEC_BITS + FW_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONFIG,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [FW_BITS-1:0]   fw_q, fw_d;
    logic [WL_W-1:0]      words_left_q, words_left_d;
    logic [NVEC_BITS-1:0] vec_left_q, vec_left_d;

    // Rotate requests so bit 0 is the current round-robin head.
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    int                   rr_sum;

    assign req_dbl = {bus.req, bus.req};
    assign req_rot = req_dbl[ptr_q +: NUM_REQ];

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        rr_sum     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!pick_found && req_rot[k]) begin
                pick_found = 1'b1;
                rr_sum     = int'(ptr_q) + k;
                if (rr_sum >= NUM_REQ) begin
                    rr_sum = rr_sum - NUM_REQ;
                end
                pick_idx = IDX_W'(rr_sum);
            end
        end
    end

    logic [FW_BITS-1:0]   sel_fw;
    logic [NVEC_BITS-1:0] sel_nvec;
    assign sel_fw   = bus.req_fetch_width[pick_idx*FW_BITS +: FW_BITS];
    assign sel_nvec = bus.req_num_vectors[pick_idx*NVEC_BITS +: NVEC_BITS];

    // Handshakes outside their legal window are dropped so the counters never underflow.
    logic deq_ok, enq_ok;
    assign deq_ok = (state_q == S_STREAM) && (words_left_q != '0) && bus.agg_sender_deq;
    assign enq_ok = ((state_q == S_STREAM) || (state_q == S_DRAIN)) &&
                    (vec_left_q != '0) && bus.agg_receiver_enq;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        ptr_d        = ptr_q;
        fw_d         = fw_q;
        words_left_d = words_left_q;
        vec_left_d   = vec_left_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    idx_d        = pick_idx;
                    fw_d         = sel_fw;
                    vec_left_d   = sel_nvec;
                    words_left_d = WL_W'(sel_nvec) * (WL_W'(sel_fw) + WL_W'(1));
                    state_d      = (sel_nvec == '0) ? S_DONE : S_CONFIG;
                end
            end
            S_CONFIG: state_d = S_STREAM;
            S_STREAM: begin
                if (deq_ok) words_left_d = words_left_q - WL_W'(1);
                if (enq_ok) vec_left_d = vec_left_q - NVEC_BITS'(1);
                // Last vector may already be out when the last word goes; skip DRAIN then.
                if (words_left_d == '0) begin
                    state_d = (vec_left_d == '0) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (enq_ok) vec_left_d = vec_left_q - NVEC_BITS'(1);
                if (vec_left_d == '0) state_d = S_DONE;
            end
            S_DONE: begin
                ptr_d   = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            ptr_q        <= '0;
            fw_q         <= '0;
            words_left_q <= '0;
            vec_left_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            ptr_q        <= ptr_d;
            fw_q         <= fw_d;
            words_left_q <= words_left_d;
            vec_left_q   <= vec_left_d;
        end
    end

    logic [NUM_REQ-1:0] idx_onehot;
    logic               granted;
    assign idx_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx_q;
    assign granted    = (state_q == S_CONFIG) || (state_q == S_STREAM) || (state_q == S_DRAIN);

    assign bus.grant                  = granted ? idx_onehot : '0;
    assign bus.done                   = (state_q == S_DONE) ? idx_onehot : '0;
    assign bus.grant_idx              = idx_q;
    assign bus.busy                   = (state_q != S_IDLE);
    assign bus.agg_change_fetch_width = (state_q == S_CONFIG);
    assign bus.agg_fetch_width        = fw_q;
    assign bus.agg_stream_en          = (state_q == S_STREAM) && (words_left_q != '0);
endmodule

// File: tb/tb_aggregator_fetch_scheduler.sv
// tb/tb_aggregator_fetch_scheduler.sv - scoreboard bench for aggregator_fetch_scheduler
module tb_aggregator_fetch_scheduler;
    localparam int NR  = 3;
    localparam int FWB = 3;
    localparam int NVB = 16;

    logic clk;
    logic rst;

    aggregator_fetch_scheduler_if #(.NUM_REQ(NR), .FW_BITS(FWB), .NVEC_BITS(NVB)) bus ();

    aggregator_fetch_scheduler #(.NUM_REQ(NR), .FW_BITS(FWB), .NVEC_BITS(NVB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int idx;
        int fw;
        int nvec;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    int            obs_n;
    logic [NR-1:0] obs_done_vec [8];
    logic [NR-1:0] obs_cfg_g    [8];
    int            obs_gidx     [8];
    int            obs_deq      [8];
    int            obs_enq      [8];
    int            obs_en       [8];
    int            obs_cfg_n    [8];
    int            obs_cfg_w    [8];
    int            obs_lat      [8];
    int            obs_done_cyc [8];
    int            obs_first    [8];
    bit            obs_idle     [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst                  = 1'b1;
        bus.req              = '0;
        bus.req_fetch_width  = '0;
        bus.req_num_vectors  = '0;
        bus.agg_sender_deq   = 1'b0;
        bus.agg_receiver_enq = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int fw, input int nv);
        bus.req[i]                        = 1'b1;
        bus.req_fetch_width[i*FWB +: FWB] = FWB'(fw);
        bus.req_num_vectors[i*NVB +: NVB] = NVB'(nv);
    endtask

    // Aggregator model: deq on every enabled cycle (optional stall), one enq the cycle after each (fw+1)-th word.
    task automatic serve(input int n_done, input int max_cyc, input int stall_at,
                         input int stall_len, input int drop_at);
        int cyc = 0, deq_c = 0, enq_c = 0, en_c = 0, cfg_n = 0, cfg_w = 0, cur_fw = 0;
        int wcnt = 0, last_enq = -100, total = 0, stall_left = 0, first_deq = -1;
        bit enq_next = 0, stall_done = 0, prev_done = 0, fin = 0;
        logic [NR-1:0] cfg_g = '0;
        obs_n = 0;
        while (!fin) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == drop_at) bus.req = '0;
            if (prev_done) begin
                obs_idle[obs_n-1] = (bus.busy == 1'b0);
                prev_done = 0;
                if (obs_n >= n_done) fin = 1;
            end
            if (!fin && cyc > max_cyc) fin = 1;
            if (!fin) begin
                if (bus.agg_change_fetch_width) begin
                    cfg_n++;
                    cfg_w  = int'(bus.agg_fetch_width);
                    cur_fw = cfg_w;
                    cfg_g  = bus.grant;
                    wcnt   = 0;
                end
                if (bus.done != '0 && obs_n < 8) begin
                    obs_done_vec[obs_n] = bus.done;
                    obs_gidx[obs_n]     = int'(bus.grant_idx);
                    obs_deq[obs_n]      = deq_c;
                    obs_enq[obs_n]      = enq_c;
                    obs_en[obs_n]       = en_c;
                    obs_cfg_n[obs_n]    = cfg_n;
                    obs_cfg_w[obs_n]    = cfg_w;
                    obs_cfg_g[obs_n]    = cfg_g;
                    obs_lat[obs_n]      = cyc - last_enq;
                    obs_done_cyc[obs_n] = cyc;
                    obs_first[obs_n]    = first_deq;
                    obs_n++;
                    deq_c = 0; enq_c = 0; en_c = 0; cfg_n = 0; first_deq = -1; cfg_g = '0;
                    prev_done = 1;
                end
                bus.agg_receiver_enq = enq_next;
                if (enq_next) begin
                    enq_c++;
                    last_enq = cyc;
                end
                enq_next = 0;
                if (bus.agg_stream_en) begin
                    en_c++;
                    if (total == stall_at && !stall_done) begin
                        stall_done = 1;
                        stall_left = stall_len;
                    end
                    if (stall_left > 0) begin
                        bus.agg_sender_deq = 1'b0;
                        stall_left--;
                    end else begin
                        bus.agg_sender_deq = 1'b1;
                        deq_c++;
                        total++;
                        if (first_deq < 0) first_deq = cyc;
                        wcnt++;
                        if (wcnt == cur_fw + 1) begin
                            wcnt     = 0;
                            enq_next = 1;
                        end
                    end
                end else begin
                    bus.agg_sender_deq = 1'b0;
                end
            end
        end
        bus.agg_sender_deq   = 1'b0;
        bus.agg_receiver_enq = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.grant !== 3'b000) begin failures++; $display("FAIL reset_grant got=%b exp=000", bus.grant); end
        checks++; if (bus.done !== 3'b000) begin failures++; $display("FAIL reset_done got=%b exp=000", bus.done); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.agg_change_fetch_width !== 1'b0) begin failures++; $display("FAIL reset_cfw got=%b exp=0", bus.agg_change_fetch_width); end
        checks++; if (bus.agg_stream_en !== 1'b0) begin failures++; $display("FAIL reset_stream_en got=%b exp=0", bus.agg_stream_en); end
        checks++; if (bus.agg_fetch_width !== 3'd0) begin failures++; $display("FAIL reset_fw got=%0d exp=0", bus.agg_fetch_width); end
        checks++; if (bus.grant_idx !== 2'd0) begin failures++; $display("FAIL reset_grant_idx got=%0d exp=0", bus.grant_idx); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        exp_t e;
        sb.push_back('{idx: 1, fw: 3, nvec: 2});
        set_req(1, 3, 2);
        serve(1, 200, -1, 0, -1);
        bus.req = '0;
        e = sb.pop_front();
        checks++; if (obs_n !== 1) begin failures++; $display("FAIL single_count got=%0d exp=1", obs_n); end
        checks++; if (obs_done_vec[0] !== NR'(1 << e.idx)) begin failures++; $display("FAIL single_done got=%b exp=%b", obs_done_vec[0], NR'(1 << e.idx)); end
        checks++; if (obs_cfg_n[0] !== 1 || obs_cfg_w[0] !== e.fw) begin failures++; $display("FAIL single_cfg got=n%0d/w%0d exp=n1/w%0d", obs_cfg_n[0], obs_cfg_w[0], e.fw); end
        checks++; if (obs_cfg_g[0] !== NR'(1 << e.idx)) begin failures++; $display("FAIL single_cfg_grant got=%b exp=%b", obs_cfg_g[0], NR'(1 << e.idx)); end
        checks++; if (obs_deq[0] !== e.nvec * (e.fw + 1) || obs_en[0] !== 8) begin failures++; $display("FAIL single_deq got=deq%0d/en%0d exp=8/8", obs_deq[0], obs_en[0]); end
        checks++; if (obs_enq[0] !== e.nvec) begin failures++; $display("FAIL single_enq got=%0d exp=%0d", obs_enq[0], e.nvec); end
        checks++; if (obs_lat[0] !== 1) begin failures++; $display("FAIL single_done_lat got=%0d exp=1", obs_lat[0]); end
        checks++; if (obs_first[0] !== 2) begin failures++; $display("FAIL single_first_deq got=%0d exp=2", obs_first[0]); end
    endtask

    task automatic test_fw0_drop();
        exp_t e;
        sb.push_back('{idx: 0, fw: 0, nvec: 5});
        set_req(0, 0, 5);
        serve(1, 200, -1, 0, 1);
        bus.req = '0;
        e = sb.pop_front();
        checks++; if (obs_n !== 1 || obs_done_vec[0] !== NR'(1 << e.idx)) begin failures++; $display("FAIL fw0_done got=n%0d/%b exp=n1/%b", obs_n, obs_done_vec[0], NR'(1 << e.idx)); end
        checks++; if (obs_deq[0] !== e.nvec * (e.fw + 1) || obs_enq[0] !== e.nvec) begin failures++; $display("FAIL fw0_counts got=deq%0d/enq%0d exp=5/5", obs_deq[0], obs_enq[0]); end
        checks++; if (obs_lat[0] !== 1) begin failures++; $display("FAIL fw0_done_lat got=%0d exp=1", obs_lat[0]); end
    endtask

    task automatic test_round_robin();
        exp_t e;
        do_reset();
        rst = 1'b0;
        set_req(0, 1, 2);
        set_req(1, 2, 1);
        set_req(2, 0, 3);
        sb.push_back('{idx: 0, fw: 1, nvec: 2});
        sb.push_back('{idx: 1, fw: 2, nvec: 1});
        sb.push_back('{idx: 2, fw: 0, nvec: 3});
        sb.push_back('{idx: 0, fw: 1, nvec: 2});
        serve(4, 400, -1, 0, -1);
        bus.req = '0;
        checks++; if (obs_n !== 4) begin failures++; $display("FAIL rr_count got=%0d exp=4", obs_n); end
        for (int k = 0; k < 4; k++) begin
            e = sb.pop_front();
            checks++; if (obs_done_vec[k] !== NR'(1 << e.idx) || obs_gidx[k] !== e.idx) begin failures++; $display("FAIL rr_order[%0d] got=%b/%0d exp=%b/%0d", k, obs_done_vec[k], obs_gidx[k], NR'(1 << e.idx), e.idx); end
            checks++; if (obs_cfg_g[k] !== NR'(1 << e.idx) || obs_cfg_w[k] !== e.fw) begin failures++; $display("FAIL rr_cfg[%0d] got=%b/%0d exp=%b/%0d", k, obs_cfg_g[k], obs_cfg_w[k], NR'(1 << e.idx), e.fw); end
            checks++; if (obs_deq[k] !== e.nvec * (e.fw + 1) || obs_enq[k] !== e.nvec) begin failures++; $display("FAIL rr_counts[%0d] got=%0d/%0d exp=%0d/%0d", k, obs_deq[k], obs_enq[k], e.nvec * (e.fw + 1), e.nvec); end
            checks++; if (obs_idle[k] !== 1'b1) begin failures++; $display("FAIL rr_idle_gap[%0d] got=%b exp=1", k, obs_idle[k]); end
        end
    endtask

    task automatic test_zero_vectors();
        exp_t e;
        sb.push_back('{idx: 2, fw: 5, nvec: 0});
        set_req(2, 5, 0);
        serve(1, 50, -1, 0, -1);
        bus.req = '0;
        e = sb.pop_front();
        checks++; if (obs_n !== 1 || obs_done_vec[0] !== NR'(1 << e.idx)) begin failures++; $display("FAIL zero_done got=n%0d/%b exp=n1/%b", obs_n, obs_done_vec[0], NR'(1 << e.idx)); end
        checks++; if (obs_cfg_n[0] !== 0 || obs_en[0] !== 0) begin failures++; $display("FAIL zero_no_stream got=cfg%0d/en%0d exp=0/0", obs_cfg_n[0], obs_en[0]); end
        checks++; if (obs_done_cyc[0] !== 1) begin failures++; $display("FAIL zero_done_time got=%0d exp=1", obs_done_cyc[0]); end
    endtask

    task automatic test_reset_mid_stream();
        exp_t e;
        int   n   = 0;
        bit   bad = 0;
        set_req(1, 1, 3);
        for (int c = 0; c < 20 && n < 3; c++) begin
            @(posedge clk);
            #1;
            if (bus.agg_stream_en) begin
                bus.agg_sender_deq = 1'b1;
                n++;
            end else begin
                bus.agg_sender_deq = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        bus.agg_sender_deq = 1'b0;
        checks++; if (n !== 3 || bus.agg_stream_en !== 1'b1) begin failures++; $display("FAIL mid_pre got=n%0d/en%b exp=3/1", n, bus.agg_stream_en); end
        rst     = 1'b1;
        bus.req = '0;
        @(posedge clk);
        #1;
        checks++; if (bus.grant !== 3'b000 || bus.busy !== 1'b0 || bus.agg_stream_en !== 1'b0) begin failures++; $display("FAIL mid_rst_out got=g%b/b%b/en%b exp=000/0/0", bus.grant, bus.busy, bus.agg_stream_en); end
        checks++; if (bus.done !== 3'b000 || bus.grant_idx !== 2'd0 || bus.agg_fetch_width !== 3'd0) begin failures++; $display("FAIL mid_rst_regs got=d%b/i%0d/w%0d exp=000/0/0", bus.done, bus.grant_idx, bus.agg_fetch_width); end
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.done !== 3'b000 || bus.busy !== 1'b0) bad = 1;
        end
        checks++; if (bad) begin failures++; $display("FAIL mid_no_done got=activity exp=none"); end
        sb.push_back('{idx: 2, fw: 2, nvec: 2});
        set_req(2, 2, 2);
        serve(1, 200, -1, 0, -1);
        bus.req = '0;
        e = sb.pop_front();
        checks++; if (obs_n !== 1 || obs_done_vec[0] !== NR'(1 << e.idx) || obs_deq[0] !== e.nvec * (e.fw + 1)) begin failures++; $display("FAIL mid_restart got=n%0d/%b/deq%0d exp=n1/%b/%0d", obs_n, obs_done_vec[0], obs_deq[0], NR'(1 << e.idx), e.nvec * (e.fw + 1)); end
    endtask

    task automatic test_stall();
        exp_t e;
        sb.push_back('{idx: 0, fw: 1, nvec: 4});
        set_req(0, 1, 4);
        serve(1, 200, 3, 4, -1);
        bus.req = '0;
        e = sb.pop_front();
        checks++; if (obs_n !== 1 || obs_done_vec[0] !== NR'(1 << e.idx)) begin failures++; $display("FAIL stall_done got=n%0d/%b exp=n1/%b", obs_n, obs_done_vec[0], NR'(1 << e.idx)); end
        checks++; if (obs_deq[0] !== e.nvec * (e.fw + 1) || obs_enq[0] !== e.nvec) begin failures++; $display("FAIL stall_counts got=%0d/%0d exp=%0d/%0d", obs_deq[0], obs_enq[0], e.nvec * (e.fw + 1), e.nvec); end
        checks++; if (obs_en[0] !== 12) begin failures++; $display("FAIL stall_en_cycles got=%0d exp=12", obs_en[0]); end
    endtask

    initial begin
        rst                  = 1'b1;
        bus.req              = '0;
        bus.req_fetch_width  = '0;
        bus.req_num_vectors  = '0;
        bus.agg_sender_deq   = 1'b0;
        bus.agg_receiver_enq = 1'b0;
        test_reset();
        test_single();
        test_fw0_drop();
        test_round_robin();
        test_zero_vectors();
        test_reset_mid_stream();
        test_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
